// File: rtl/branch_unit_pkg.sv
// Shared definitions for the branch unit: condition-mode encodings and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package branch_unit_pkg;

    // Branch condition select carried on br_mode.
    typedef enum logic [2:0] {
        BR_NEVER = 3'b000,
        BR_BEQ   = 3'b001,
        BR_BNE   = 3'b010,
        BR_BLT   = 3'b011,
        BR_BGE   = 3'b100,
        BR_BLTU  = 3'b101,
        BR_JMP   = 3'b110,
        BR_RSVD  = 3'b111
    } br_mode_t;

    // Control FSM states; only IDLE accepts new requests.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int FLUSH_CNT_W = 4;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: compares two operands under the selected mode.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module branch_cond
    import branch_unit_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  br_mode_t            mode,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic                cond
);

    // Decode the mode into a single taken/not-taken decision.
    always_comb begin
        cond = 1'b0;
        case (mode)
            BR_NEVER: cond = 1'b0;
            BR_BEQ:   cond = (a == b);
            BR_BNE:   cond = (a != b);
            BR_BLT:   cond = ($signed(a) < $signed(b));
            BR_BGE:   cond = ($signed(a) >= $signed(b));
            BR_BLTU:  cond = (a < b);
            BR_JMP:   cond = 1'b1;
            default:  cond = 1'b0;   // reserved encoding is never taken
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution unit: captures a request, decides taken/not-taken, computes next PC, flushes.
// Latency: result strobe (valid_out/taken/target) one cycle after the EVAL cycle; flush for FLUSH_CYC cycles on taken.
// Backpressure: ready is high only in IDLE; valid_in and all other inputs are ignored while ready is low.
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int OFF_W     = 8,
    parameter int FLUSH_CYC = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                valid_in,
    output logic                ready,
    input  logic [2:0]          br_mode,
    input  logic [DATA_W-1:0]   op_a,
    input  logic [DATA_W-1:0]   op_b,
    input  logic [ADDR_W-1:0]   pc_in,
    input  logic [OFF_W-1:0]    offset,
    output logic                valid_out,
    output logic                taken,
    output logic [ADDR_W-1:0]   target,
    output logic                flush
);

    // Counter value loaded on entry to FLUSH; FLUSH exits when it reaches zero.
    localparam bit                     HAS_FLUSH  = (FLUSH_CYC > 0);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = HAS_FLUSH ? FLUSH_CNT_W'(FLUSH_CYC - 1)
                                                              : '0;

    state_t                  state_q;
    state_t                  state_d;
    logic                    accept;

    br_mode_t                mode_q;
    logic [DATA_W-1:0]       a_q;
    logic [DATA_W-1:0]       b_q;
    logic [ADDR_W-1:0]       pc_q;
    logic [OFF_W-1:0]        off_q;
    logic [FLUSH_CNT_W-1:0]  cnt_q;

    logic                    cond;
    logic [ADDR_W-1:0]       pc_seq;
    logic signed [ADDR_W-1:0] off_ext;
    logic [ADDR_W-1:0]       target_d;

    assign accept = valid_in && (state_q == ST_IDLE);

    branch_cond #(
        .DATA_W (DATA_W)
    ) u_cond (
        .mode   (mode_q),
        .a      (a_q),
        .b      (b_q),
        .cond   (cond)
    );

    // Next-PC arithmetic wraps modulo 2^ADDR_W by construction of the widths.
    assign pc_seq   = pc_q + ADDR_W'(1);
    assign off_ext  = ADDR_W'($signed(off_q));
    assign target_d = cond ? (pc_seq + $unsigned(off_ext)) : pc_seq;

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and handshake/flush outputs.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        flush   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (valid_in) begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                state_d = (cond && HAS_FLUSH) ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: begin
                flush = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Capture the request on acceptance so later input changes cannot disturb it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q <= BR_NEVER;
            a_q    <= '0;
            b_q    <= '0;
            pc_q   <= '0;
            off_q  <= '0;
        end else if (accept) begin
            mode_q <= br_mode_t'(br_mode);
            a_q    <= op_a;
            b_q    <= op_b;
            pc_q   <= pc_in;
            off_q  <= offset;
        end
    end

    // Register the decision at the end of EVAL; taken/target hold until the next evaluation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_out <= 1'b0;
            taken     <= 1'b0;
            target    <= '0;
        end else begin
            valid_out <= (state_q == ST_EVAL);
            if (state_q == ST_EVAL) begin
                taken  <= cond;
                target <= target_d;
            end
        end
    end

    // Flush-length counter: loaded leaving EVAL, counts down while in FLUSH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == ST_EVAL) begin
            cnt_q <= FLUSH_LAST;
        end else if ((state_q == ST_FLUSH) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - FLUSH_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit (default flush length plus a zero-flush instance).
// Latency: n/a.
// Backpressure: n/a.
module tb_branch_unit;
    import branch_unit_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        valid0;
    logic [2:0]  br_mode;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] pc_in;
    logic [7:0]  offset;

    logic        ready,  valid_out,  taken,  flush;
    logic [15:0] target;
    logic        ready0, valid_out0, taken0, flush0;
    logic [15:0] target0;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    branch_unit #(
        .DATA_W(16), .ADDR_W(16), .OFF_W(8), .FLUSH_CYC(2)
    ) dut (
        .clock(clock), .reset(reset), .valid_in(valid_in), .ready(ready),
        .br_mode(br_mode), .op_a(op_a), .op_b(op_b), .pc_in(pc_in), .offset(offset),
        .valid_out(valid_out), .taken(taken), .target(target), .flush(flush)
    );

    branch_unit #(
        .DATA_W(16), .ADDR_W(16), .OFF_W(8), .FLUSH_CYC(0)
    ) dut0 (
        .clock(clock), .reset(reset), .valid_in(valid0), .ready(ready0),
        .br_mode(br_mode), .op_a(op_a), .op_b(op_b), .pc_in(pc_in), .offset(offset),
        .valid_out(valid_out0), .taken(taken0), .target(target0), .flush(flush0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input br_mode_t m, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] pc, input logic [7:0] off);
        br_mode = m;
        op_a    = a;
        op_b    = b;
        pc_in   = pc;
        offset  = off;
    endtask

    // Called at a negedge with the unit idle; returns at the negedge of the result cycle.
    task automatic run_req(input br_mode_t m, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] pc, input logic [7:0] off);
        set_req(m, a, b, pc, off);
        valid_in = 1'b1;
        @(negedge clock);
        valid_in = 1'b0;
        @(negedge clock);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (ready) break;
            @(negedge clock);
        end
        chk(tag, ready, 1);
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        valid0   = 1'b0;
        set_req(BR_NEVER, 16'h0, 16'h0, 16'h0, 8'h0);

        // Reset values before any clock edge.
        #1;
        chk("rst_ready",  ready, 1);
        chk("rst_vout",   valid_out, 0);
        chk("rst_taken",  taken, 0);
        chk("rst_target", target, 16'h0000);
        chk("rst_flush",  flush, 0);

        // BEQ taken, presented in the first cycle after reset release; valid_in stays high.
        @(negedge clock);
        reset = 1'b0;
        set_req(BR_BEQ, 16'h1234, 16'h1234, 16'h0010, 8'h05);
        valid_in = 1'b1;
        @(negedge clock);
        chk("beq_eval_ready", ready, 0);
        chk("beq_eval_vout",  valid_out, 0);
        set_req(BR_BNE, 16'h1234, 16'h1234, 16'h0200, 8'h7F);   // must be ignored
        @(negedge clock);
        chk("beq_vout",   valid_out, 1);
        chk("beq_taken",  taken, 1);
        chk("beq_target", target, 16'h0016);
        chk("beq_flush1", flush, 1);
        chk("beq_ready1", ready, 0);
        set_req(BR_BNE, 16'h0001, 16'h0002, 16'h0100, 8'h02);
        @(negedge clock);
        chk("beq_vout_once", valid_out, 0);
        chk("beq_flush2",    flush, 1);
        chk("beq_ready2",    ready, 0);
        @(negedge clock);
        chk("beq_reidle_ready", ready, 1);
        chk("beq_reidle_flush", flush, 0);
        chk("beq_hold_taken",   taken, 1);
        chk("beq_hold_target",  target, 16'h0016);
        // Held request is taken on the IDLE re-entry edge.
        @(negedge clock);
        chk("b2b_accepted", ready, 0);
        valid_in = 1'b0;
        @(negedge clock);
        chk("b2b_vout",   valid_out, 1);
        chk("b2b_taken",  taken, 1);
        chk("b2b_target", target, 16'h0103);
        @(negedge clock);
        chk("b2b_flush", flush, 1);
        @(negedge clock);
        chk("b2b_idle", ready, 1);

        // Signed vs unsigned less-than on the same operands.
        run_req(BR_BLT, 16'hFFFF, 16'h0001, 16'h0040, 8'h03);
        chk("blt_taken",  taken, 1);
        chk("blt_target", target, 16'h0044);
        wait_idle("blt_idle");
        run_req(BR_BLTU, 16'hFFFF, 16'h0001, 16'h0040, 8'h03);
        chk("bltu_vout",   valid_out, 1);
        chk("bltu_taken",  taken, 0);
        chk("bltu_target", target, 16'h0041);
        chk("bltu_flush",  flush, 0);
        chk("bltu_ready",  ready, 1);

        // JMP with negative offset wrapping below zero.
        @(negedge clock);
        run_req(BR_JMP, 16'h0000, 16'h0000, 16'h0002, 8'hF0);
        chk("jmp_taken",  taken, 1);
        chk("jmp_target", target, 16'hFFF3);
        chk("jmp_flush",  flush, 1);
        wait_idle("jmp_idle");

        // Signed GE, BNE and the never-taken encodings.
        run_req(BR_BGE, 16'h8000, 16'h7FFF, 16'h0300, 8'h10);
        chk("bge_neg_taken",  taken, 0);
        chk("bge_neg_target", target, 16'h0301);
        wait_idle("bge_neg_idle");
        run_req(BR_BGE, 16'h0005, 16'h0005, 16'h0300, 8'hFE);
        chk("bge_eq_taken",  taken, 1);
        chk("bge_eq_target", target, 16'h02FF);
        wait_idle("bge_eq_idle");
        run_req(BR_BNE, 16'hABCD, 16'hABCD, 16'h0400, 8'h08);
        chk("bne_eq_taken", taken, 0);
        wait_idle("bne_eq_idle");
        run_req(BR_RSVD, 16'h5555, 16'h5555, 16'h1000, 8'h10);
        chk("rsvd_taken",  taken, 0);
        chk("rsvd_target", target, 16'h1001);
        chk("rsvd_flush",  flush, 0);
        wait_idle("rsvd_idle");
        run_req(BR_NEVER, 16'h5555, 16'h5555, 16'h2000, 8'h10);
        chk("never_taken",  taken, 0);
        chk("never_target", target, 16'h2001);
        chk("never_flush",  flush, 0);
        wait_idle("never_idle");

        // Reset pulsed in the middle of FLUSH.
        run_req(BR_JMP, 16'h0000, 16'h0000, 16'h0050, 8'h04);
        chk("rf_in_flush", flush, 1);
        #1 reset = 1'b1;
        #1;
        chk("rf_ready",  ready, 1);
        chk("rf_vout",   valid_out, 0);
        chk("rf_taken",  taken, 0);
        chk("rf_target", target, 16'h0000);
        chk("rf_flush",  flush, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rf_post_ready", ready, 1);
        chk("rf_post_flush", flush, 0);
        chk("rf_post_vout",  valid_out, 0);
        @(negedge clock);
        chk("rf_post2_flush", flush, 0);
        chk("rf_post2_vout",  valid_out, 0);

        // Zero-length flush instance: no flush, two-cycle request spacing.
        set_req(BR_JMP, 16'h0000, 16'h0000, 16'h0010, 8'h01);
        valid0 = 1'b1;
        @(negedge clock);
        chk("nf_eval_ready", ready0, 0);
        @(negedge clock);
        chk("nf_vout",   valid_out0, 1);
        chk("nf_taken",  taken0, 1);
        chk("nf_target", target0, 16'h0012);
        chk("nf_flush",  flush0, 0);
        chk("nf_ready",  ready0, 1);
        @(negedge clock);
        chk("nf_b2b_accept", ready0, 0);
        chk("nf_b2b_vout0",  valid_out0, 0);
        valid0 = 1'b0;
        @(negedge clock);
        chk("nf_b2b_vout",  valid_out0, 1);
        chk("nf_b2b_flush", flush0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
